warp_xwb: RTL and testbench

Integer writeback stage for the scalar pipeline. Collects results from the single-cycle arith/logic/shift path, the pipelined multiplier and the variable-latency divider, and drives the two write ports of the integer register file. Holds the destination tag of the in-flight divide, buffers completed divide results in a small FIFO, and exports a pending-register bitmap for the issue logic's hazard checks.

---
 rtl/warp_xwb.sv | 157 +++++++++++++++
 tb/tb_warp_xwb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_xwb.sv
// Integer writeback stage: fx pass-through on port 1, mul / divide-FIFO on port 2.
// Optional same-cycle divide bypass to port 2 when `WARP_XWB_DIV_BYPASS_EN is defined.
module warp_xwb #(
   parameter int DIV_FIFO_DEPTH = 4,
   parameter int DATA_W         = 64
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_fx_valid,
   input  logic [4:0]                        i_fx_rd,
   input  logic [DATA_W-1:0]                 i_fx_data,
   input  logic                              i_mul_valid,
   input  logic [4:0]                        i_mul_rd,
   input  logic [DATA_W-1:0]                 i_mul_data,
   input  logic                              i_div_issue_valid,
   input  logic [4:0]                        i_div_issue_rd,
   input  logic                              i_div_issue_rem,
   input  logic                              i_div_input_ready,
   output logic                              o_div_issue_ready,
   input  logic                              i_div_valid,
   input  logic [DATA_W-1:0]                 i_div_quotient,
   input  logic [DATA_W-1:0]                 i_div_remainder,
   output logic [4:0]                        o_rd1_addr,
   output logic [DATA_W-1:0]                 o_rd1_wdata,
   output logic                              o_rd1_wen,
   output logic [4:0]                        o_rd2_addr,
   output logic [DATA_W-1:0]                 o_rd2_wdata,
   output logic                              o_rd2_wen,
   output logic [31:0]                       o_pending,
   output logic [$clog2(DIV_FIFO_DEPTH):0]   o_fifo_count
);

   localparam int PTR_W = $clog2(DIV_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]        fifo_rd   [DIV_FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [DIV_FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;

   logic              tag_valid, tag_rem;
   logic [4:0]        tag_rd;
   logic [31:0]       pending;

   logic              div_done, fifo_empty, bypass, push, pop, issue_fire;
   logic [DATA_W-1:0] div_result;
   logic [4:0]        head_rd;
   logic [DATA_W-1:0] head_data;
   logic              p1_en, p2_en, collide;
   logic [4:0]        p2_addr;
   logic [DATA_W-1:0] p2_data;
   logic [31:0]       clr_vec, set_vec;

   function automatic logic [DATA_W-1:0] div_select(input logic rem,
                                                   input logic [DATA_W-1:0] quo,
                                                   input logic [DATA_W-1:0] rmd);
      return rem ? rmd : quo;
   endfunction

   assign div_done   = i_div_valid & tag_valid;
   assign div_result = div_select(tag_rem, i_div_quotient, i_div_remainder);
   assign fifo_empty = (count == '0);
   assign head_rd    = fifo_rd[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

`ifdef WARP_XWB_DIV_BYPASS_EN
   assign bypass = div_done & fifo_empty & ~i_mul_valid;
`else
   assign bypass = 1'b0;
`endif

   assign push = div_done & ~bypass;
   assign pop  = ~i_mul_valid & ~fifo_empty;

   // Issue uses current-state pending, so a same-cycle pop of rd still blocks it.
   assign o_div_issue_ready = ~tag_valid & (count < CNT_W'(DIV_FIFO_DEPTH)) &
                              i_div_input_ready & ~pending[i_div_issue_rd];
   assign issue_fire = i_div_issue_valid & o_div_issue_ready;

   always_comb begin
      p2_en   = 1'b0;
      p2_addr = '0;
      p2_data = '0;
      clr_vec = '0;
      if (i_mul_valid) begin
         p2_en   = (i_mul_rd != 5'd0);
         p2_addr = i_mul_rd;
         p2_data = i_mul_data;
      end else if (pop) begin
         p2_en            = (head_rd != 5'd0);
         p2_addr          = head_rd;
         p2_data          = head_data;
         clr_vec[head_rd] = 1'b1;
      end else if (bypass) begin
         p2_en           = (tag_rd != 5'd0);
         p2_addr         = tag_rd;
         p2_data         = div_result;
         clr_vec[tag_rd] = 1'b1;
      end
   end

   always_comb begin
      set_vec = '0;
      if (issue_fire && (i_div_issue_rd != 5'd0))
         set_vec[i_div_issue_rd] = 1'b1;
   end

   // Port 1 carries the younger result, so it wins an address collision.
   assign p1_en   = i_fx_valid & (i_fx_rd != 5'd0);
   assign collide = p1_en & p2_en & (p2_addr == i_fx_rd);

   assign o_rd1_wen   = p1_en;
   assign o_rd1_addr  = p1_en ? i_fx_rd : 5'd0;
   assign o_rd1_wdata = p1_en ? i_fx_data : '0;

   assign o_rd2_wen   = p2_en & ~collide;
   assign o_rd2_addr  = o_rd2_wen ? p2_addr : 5'd0;
   assign o_rd2_wdata = o_rd2_wen ? p2_data : '0;

   assign o_pending    = pending;
   assign o_fifo_count = count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         tag_valid <= 1'b0;
         tag_rd    <= 5'd0;
         tag_rem   <= 1'b0;
         pending   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (issue_fire) begin
            tag_valid <= 1'b1;
            tag_rd    <= i_div_issue_rd;
            tag_rem   <= i_div_issue_rem;
         end else if (i_div_valid) begin
            tag_valid <= 1'b0;
         end
         pending <= ((pending & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
      end
   end

   // Entry storage carries no control meaning, so it is left unreset.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= tag_rd;
         fifo_data[wr_ptr] <= div_result;
      end
   end

endmodule

// File: tb/tb_warp_xwb.sv
// Self-checking bench for warp_xwb: queue-based writeback model plus directed vectors.
module tb_warp_xwb;

   localparam int DEPTH = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_fx_valid, i_mul_valid, i_div_issue_valid, i_div_issue_rem;
   logic        i_div_input_ready, i_div_valid;
   logic [4:0]  i_fx_rd, i_mul_rd, i_div_issue_rd;
   logic [63:0] i_fx_data, i_mul_data, i_div_quotient, i_div_remainder;
   logic        o_div_issue_ready, o_rd1_wen, o_rd2_wen;
   logic [4:0]  o_rd1_addr, o_rd2_addr;
   logic [63:0] o_rd1_wdata, o_rd2_wdata;
   logic [31:0] o_pending;
   logic [2:0]  o_fifo_count;

   int checks = 0;
   int failures = 0;

   warp_xwb #(.DIV_FIFO_DEPTH(DEPTH), .DATA_W(64)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_fx_valid(i_fx_valid), .i_fx_rd(i_fx_rd), .i_fx_data(i_fx_data),
      .i_mul_valid(i_mul_valid), .i_mul_rd(i_mul_rd), .i_mul_data(i_mul_data),
      .i_div_issue_valid(i_div_issue_valid), .i_div_issue_rd(i_div_issue_rd),
      .i_div_issue_rem(i_div_issue_rem), .i_div_input_ready(i_div_input_ready),
      .o_div_issue_ready(o_div_issue_ready),
      .i_div_valid(i_div_valid), .i_div_quotient(i_div_quotient),
      .i_div_remainder(i_div_remainder),
      .o_rd1_addr(o_rd1_addr), .o_rd1_wdata(o_rd1_wdata), .o_rd1_wen(o_rd1_wen),
      .o_rd2_addr(o_rd2_addr), .o_rd2_wdata(o_rd2_wdata), .o_rd2_wen(o_rd2_wen),
      .o_pending(o_pending), .o_fifo_count(o_fifo_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pend;
   logic        m_tag_v, m_tag_rem;
   logic [4:0]  m_tag_rd;
   logic        m_fire, m_done, m_byp;

   function automatic logic m_ready();
      return !m_tag_v && (q.size() < DEPTH) && i_div_input_ready && !m_pend[i_div_issue_rd];
   endfunction

   function automatic logic m_bypass();
`ifdef WARP_XWB_DIV_BYPASS_EN
      return i_div_valid && m_tag_v && (q.size() == 0) && !i_mul_valid;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q.delete();
         m_pend    = '0;
         m_tag_v   = 1'b0;
         m_tag_rd  = '0;
         m_tag_rem = 1'b0;
      end else begin
         m_fire = i_div_issue_valid && m_ready();
         m_done = i_div_valid && m_tag_v;
         m_byp  = m_bypass();
         if (!i_mul_valid && q.size() > 0) begin
            m_pend[q[0].rd] = 1'b0;
            void'(q.pop_front());
         end
         if (m_byp)
            m_pend[m_tag_rd] = 1'b0;
         if (m_done && !m_byp)
            q.push_back('{rd: m_tag_rd, data: (m_tag_rem ? i_div_remainder : i_div_quotient)});
         if (m_done)
            m_tag_v = 1'b0;
         if (m_fire) begin
            m_tag_v   = 1'b1;
            m_tag_rd  = i_div_issue_rd;
            m_tag_rem = i_div_issue_rem;
            if (i_div_issue_rd != 5'd0)
               m_pend[i_div_issue_rd] = 1'b1;
         end
      end
   end

   // Compare all outputs against the model on every falling edge.
   always @(negedge i_clk) begin
      logic        e_w1, e_w2, has2;
      logic [4:0]  a2;
      logic [63:0] d2;
      e_w1 = i_fx_valid && (i_fx_rd != 5'd0);
      has2 = 1'b0;
      a2   = '0;
      d2   = '0;
      if (i_mul_valid) begin
         has2 = 1'b1; a2 = i_mul_rd; d2 = i_mul_data;
      end else if (q.size() > 0) begin
         has2 = 1'b1; a2 = q[0].rd; d2 = q[0].data;
      end else if (m_bypass()) begin
         has2 = 1'b1; a2 = m_tag_rd; d2 = m_tag_rem ? i_div_remainder : i_div_quotient;
      end
      e_w2 = has2 && (a2 != 5'd0) && !(e_w1 && (a2 == i_fx_rd));
      chk("m_wen1",  64'(o_rd1_wen), 64'(e_w1));
      chk("m_addr1", 64'(o_rd1_addr), e_w1 ? 64'(i_fx_rd) : 64'd0);
      chk("m_data1", o_rd1_wdata, e_w1 ? i_fx_data : 64'd0);
      chk("m_wen2",  64'(o_rd2_wen), 64'(e_w2));
      chk("m_addr2", 64'(o_rd2_addr), e_w2 ? 64'(a2) : 64'd0);
      chk("m_data2", o_rd2_wdata, e_w2 ? d2 : 64'd0);
      chk("m_pend",  64'(o_pending), 64'(m_pend));
      chk("m_count", 64'(o_fifo_count), 64'(q.size()));
      chk("m_ready", 64'(o_div_issue_ready), 64'(m_ready()));
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      i_rst_n = 1'b0;
      i_fx_valid = 0; i_fx_rd = 0; i_fx_data = 0;
      i_mul_valid = 0; i_mul_rd = 0; i_mul_data = 0;
      i_div_issue_valid = 0; i_div_issue_rd = 0; i_div_issue_rem = 0;
      i_div_input_ready = 1; i_div_valid = 0; i_div_quotient = 0; i_div_remainder = 0;

      repeat (3) tick();
      chk("rst_pend", 64'(o_pending), 64'd0);
      chk("rst_count", 64'(o_fifo_count), 64'd0);
      chk("rst_wen1", 64'(o_rd1_wen), 64'd0);
      chk("rst_wen2", 64'(o_rd2_wen), 64'd0);
      chk("rst_ready", 64'(o_div_issue_ready), 64'd1);
      tick(); i_rst_n = 1'b1;

      // fx pass-through
      tick(); i_fx_valid = 1; i_fx_rd = 5; i_fx_data = 64'hDEAD; #1;
      chk("fx_wen", 64'(o_rd1_wen), 64'd1);
      chk("fx_addr", 64'(o_rd1_addr), 64'd5);
      chk("fx_data", o_rd1_wdata, 64'hDEAD);
      tick(); i_fx_rd = 0; #1;
      chk("fx_x0_wen", 64'(o_rd1_wen), 64'd0);
      chk("fx_x0_addr", 64'(o_rd1_addr), 64'd0);

      // divide rd=7 remainder
      tick(); i_fx_valid = 0; i_div_issue_valid = 1; i_div_issue_rd = 7; i_div_issue_rem = 1; #1;
      chk("div_ready", 64'(o_div_issue_ready), 64'd1);
      tick(); i_div_issue_valid = 0; #1;
      chk("div_pend7", 64'(o_pending), 64'h80);
      chk("div_tag_block", 64'(o_div_issue_ready), 64'd0);
      tick(); i_div_valid = 1; i_div_quotient = 3; i_div_remainder = 1; #1;
`ifdef WARP_XWB_DIV_BYPASS_EN
      chk("div_byp_wen", 64'(o_rd2_wen), 64'd1);
      chk("div_byp_data", o_rd2_wdata, 64'd1);
`else
      chk("div_n_wen", 64'(o_rd2_wen), 64'd0);
      chk("div_n_pend", 64'(o_pending), 64'h80);
`endif
      tick(); i_div_valid = 0; #1;
`ifdef WARP_XWB_DIV_BYPASS_EN
      chk("div_n1_pend", 64'(o_pending), 64'd0);
`else
      chk("div_n1_count", 64'(o_fifo_count), 64'd1);
      chk("div_n1_wen", 64'(o_rd2_wen), 64'd1);
      chk("div_n1_addr", 64'(o_rd2_addr), 64'd7);
      chk("div_n1_data", o_rd2_wdata, 64'd1);
`endif
      tick(); #1;
      chk("div_done_pend", 64'(o_pending), 64'd0);
      chk("div_done_count", 64'(o_fifo_count), 64'd0);

      // mul starves FIFO for 3 cycles
      tick(); i_div_issue_valid = 1; i_div_issue_rd = 3; i_div_issue_rem = 0;
      tick(); i_div_issue_valid = 0;
      tick(); i_div_valid = 1; i_div_quotient = 64'h55; i_div_remainder = 64'h66;
      i_mul_valid = 1; i_mul_rd = 9; i_mul_data = 64'h99; #1;
      chk("mul1_addr", 64'(o_rd2_addr), 64'd9);
      chk("mul1_data", o_rd2_wdata, 64'h99);
      tick(); i_div_valid = 0; #1;
      chk("mul2_count", 64'(o_fifo_count), 64'd1);
      chk("mul2_pend", 64'(o_pending), 64'h8);
      tick(); #1;
      chk("mul3_addr", 64'(o_rd2_addr), 64'd9);
      tick(); i_mul_valid = 0; #1;
      chk("mul4_addr", 64'(o_rd2_addr), 64'd3);
      chk("mul4_data", o_rd2_wdata, 64'h55);
      tick(); #1;
      chk("mul5_count", 64'(o_fifo_count), 64'd0);

      // fx / FIFO head collision on x4
      tick(); i_div_issue_valid = 1; i_div_issue_rd = 4;
      tick(); i_div_issue_valid = 0;
      tick(); i_div_valid = 1; i_div_quotient = 64'h44; i_mul_valid = 1; i_mul_rd = 10; i_mul_data = 64'hA0;
      tick(); i_div_valid = 0; i_mul_valid = 0; i_fx_valid = 1; i_fx_rd = 4; i_fx_data = 64'hF4; #1;
      chk("col_wen1", 64'(o_rd1_wen), 64'd1);
      chk("col_data1", o_rd1_wdata, 64'hF4);
      chk("col_wen2", 64'(o_rd2_wen), 64'd0);
      chk("col_count", 64'(o_fifo_count), 64'd1);
      tick(); i_fx_valid = 0; #1;
      chk("col_after_count", 64'(o_fifo_count), 64'd0);
      chk("col_after_pend", 64'(o_pending), 64'd0);

      // blocked issue: pending rd and tag valid
      tick(); i_div_issue_valid = 1; i_div_issue_rd = 7;
      tick(); i_div_issue_valid = 0;
      tick(); i_div_valid = 1; i_div_quotient = 64'h77; i_mul_valid = 1; i_mul_rd = 12; i_mul_data = 64'hC;
      tick(); i_div_valid = 0; i_div_issue_valid = 1; i_div_issue_rd = 7; #1;
      chk("blk_pend_ready", 64'(o_div_issue_ready), 64'd0);
      i_div_issue_valid = 0; i_div_issue_rd = 8; #1;
      chk("blk_other_ready", 64'(o_div_issue_ready), 64'd1);
      i_div_input_ready = 0; #1;
      chk("blk_inrdy_ready", 64'(o_div_issue_ready), 64'd0);
      i_div_input_ready = 1;
      tick(); i_div_issue_valid = 1; i_div_issue_rd = 8;
      tick(); i_div_issue_valid = 0; i_div_issue_rd = 11; #1;
      chk("blk_tag_ready", 64'(o_div_issue_ready), 64'd0);
      chk("blk_pend", 64'(o_pending), 64'h180);

      // reset mid-divide
      tick(); #2; i_mul_valid = 0; i_rst_n = 1'b0; #1;
      chk("mrst_pend", 64'(o_pending), 64'd0);
      chk("mrst_count", 64'(o_fifo_count), 64'd0);
      chk("mrst_wen2", 64'(o_rd2_wen), 64'd0);
      chk("mrst_ready1", 64'(o_div_issue_ready), 64'd1);
      i_div_input_ready = 0; #1;
      chk("mrst_ready0", 64'(o_div_issue_ready), 64'd0);
      i_div_input_ready = 1;
      tick(); tick(); i_rst_n = 1'b1;
      tick(); i_div_issue_rd = 7; #1;
      chk("post_ready", 64'(o_div_issue_ready), 64'd1);

      // completion with no tag is ignored
      tick(); i_div_valid = 1; i_div_quotient = 64'h99;
      tick(); i_div_valid = 0; #1;
      chk("orphan_count", 64'(o_fifo_count), 64'd0);
      chk("orphan_wen2", 64'(o_rd2_wen), 64'd0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
